// File: rtl/uart_crc_pkg.sv
// uart_crc_pkg: CRC-8 constants, bytewise CRC helper and bit-FSM states shared by both link directions
package uart_crc_pkg;
  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? {c[6:0], 1'b0} ^ CRC_POLY : {c[6:0], 1'b0};
    return c;
  endfunction
endpackage

// File: rtl/uart_crc_frame_rx_if.sv
// uart_crc_frame_rx_if: serial input and per-byte / per-frame result pulses of the receive endpoint
interface uart_crc_frame_rx_if;
  logic       rx_serial;
  logic [7:0] rx_data_out;
  logic       rx_ready_out;
  logic       crc_valid_out;
  logic       crc_error_out;
  logic       frame_error_out;
  modport master (output rx_serial, input rx_data_out, rx_ready_out, crc_valid_out, crc_error_out, frame_error_out);
  modport slave (input rx_serial, output rx_data_out, rx_ready_out, crc_valid_out, crc_error_out, frame_error_out);
endinterface

// File: rtl/uart_crc_rx_phy.sv
// uart_crc_rx_phy: synchronizes the serial line and deserializes 8N1 bytes with a mid-bit sampling FSM
module uart_crc_rx_phy
  import uart_crc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       stop_error,
  output logic       idle,
  output logic       start
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [1:0] sync;
  logic rx_s, half_done, bit_done;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  rx_state_e state, state_n;
  assign rx_s = sync[1];
  assign half_done = cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign bit_done = cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= 2'b11;
    else sync <= {sync[0], rx_serial};
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = rx_s ? IDLE : START;
      START:   if (half_done) state_n = rx_s ? IDLE : DATA;
      DATA:    if (bit_done && bit_idx == 3'd7) state_n = STOP;
      STOP:    if (bit_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    idle = state == IDLE;
    start = idle && !rx_s;
    byte_valid = state == STOP && bit_done && rx_s;
    stop_error = state == STOP && bit_done && !rx_s;
  end
  // the tick counter restarts at the start-bit midpoint so later ticks land mid-bit
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      bit_idx <= '0;
      rx_byte <= '0;
    end else begin
      cnt <= (idle || (state == START && half_done) || bit_done) ? '0 : cnt + 1'b1;
      if (state == DATA && bit_done) begin
        rx_byte <= {rx_s, rx_byte[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
endmodule

// File: rtl/uart_crc_frame_rx.sv
// uart_crc_frame_rx: groups received bytes into payload+CRC-8 frames and reports data, CRC result and frame errors
module uart_crc_frame_rx
  import uart_crc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FRAME_LEN    = 1,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic clk,
  input  logic reset,
  uart_crc_frame_rx_if.slave bus
);
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_CYC);
  logic [7:0] rx_byte, byte_idx, crc;
  logic byte_valid, stop_error, phy_idle, phy_start, to_hit;
  logic [TW-1:0] to_cnt;
  uart_crc_rx_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
    .clk(clk),
    .reset(reset),
    .rx_serial(bus.rx_serial),
    .rx_byte(rx_byte),
    .byte_valid(byte_valid),
    .stop_error(stop_error),
    .idle(phy_idle),
    .start(phy_start)
  );
  // expiry ignores a coincident start so the new byte begins a fresh frame
  assign to_hit = phy_idle && byte_idx != 8'd0 && to_cnt == TW'(TO_CYC - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) to_cnt <= '0;
    else to_cnt <= (!phy_idle || byte_idx == 8'd0 || phy_start || to_hit) ? '0 : to_cnt + 1'b1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      byte_idx <= '0;
      crc <= CRC_INIT;
      bus.rx_data_out <= '0;
      bus.rx_ready_out <= 1'b0;
      bus.crc_valid_out <= 1'b0;
      bus.crc_error_out <= 1'b0;
      bus.frame_error_out <= 1'b0;
    end else begin
      bus.rx_ready_out <= 1'b0;
      bus.crc_valid_out <= 1'b0;
      bus.crc_error_out <= 1'b0;
      bus.frame_error_out <= stop_error || to_hit;
      if (stop_error || to_hit) begin
        byte_idx <= '0;
        crc <= CRC_INIT;
      end else if (byte_valid && byte_idx < 8'(FRAME_LEN)) begin
        bus.rx_data_out <= rx_byte;
        bus.rx_ready_out <= 1'b1;
        crc <= crc8_byte(crc, rx_byte);
        byte_idx <= byte_idx + 1'b1;
      end else if (byte_valid) begin
        bus.crc_valid_out <= rx_byte == crc;
        bus.crc_error_out <= rx_byte != crc;
        byte_idx <= '0;
        crc <= CRC_INIT;
      end
    end
endmodule
